// File: rtl/servo_scan_pkg.sv
// servo_scan_pkg: shared state encoding, position codes and constants for the servo scan sequencer
package servo_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_TRIG,
        ST_WAIT,
        ST_PARK,
        ST_DONE
    } state_t;

    localparam logic [1:0] POS_P0 = 2'b00;
    localparam logic [1:0] POS_P1 = 2'b01;
    localparam logic [1:0] POS_P2 = 2'b10;

    localparam int DEF_SETTLE_CYCLES  = 30_000_000;
    localparam int DEF_TIMEOUT_CYCLES = 3_000_000;
    localparam int DEF_DIST_W         = 16;

    // Wide all-ones pattern, truncated to the distance width at the point of use
    localparam logic [63:0] DIST_TIMEOUT = '1;

    // Bits needed to hold the larger of the two reload values (count-1), at least one bit
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/servo_scan_ctrl_timer.sv
// scan_timer: loadable down-counter that stops at zero, shared by the settle and timeout phases
module scan_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    // Reload has priority; otherwise count down and hold at zero
    always_comb begin
        cnt_d = load ? load_val : ((cnt_q != '0) ? cnt_q - W'(1) : cnt_q);
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/servo_scan_ctrl.sv
// servo_scan_ctrl: sweeps the servo over three positions, ranging once at each after it settles
module servo_scan_ctrl
    import servo_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int DIST_W         = DEF_DIST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [1:0]        pos,
    output logic              us_trig,
    input  logic              us_done,
    input  logic [DIST_W-1:0] us_dist,
    output logic [DIST_W-1:0] dist_p0,
    output logic [DIST_W-1:0] dist_p1,
    output logic [DIST_W-1:0] dist_p2,
    output logic [2:0]        timeout_flags
);

    localparam int TW = timer_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam logic [TW-1:0] SETTLE_LOAD  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        pos_q, pos_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              trig_q, trig_d;
    logic [2:0]        flags_q, flags_d;
    logic [DIST_W-1:0] dist_q [3];
    logic [DIST_W-1:0] dist_d [3];
    logic              tmr_load, tmr_zero;
    logic [TW-1:0]     tmr_val;

    scan_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Sequencer next-state: every output is registered, so pulses are set on entry to their state
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pos_d    = pos_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        trig_d   = 1'b0;
        flags_d  = flags_q;
        dist_d   = dist_q;
        tmr_load = 1'b0;
        tmr_val  = SETTLE_LOAD;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d  = ST_SETTLE;
                idx_d    = 2'd0;
                pos_d    = POS_P0;
                busy_d   = 1'b1;
                flags_d  = 3'b000;
                tmr_load = 1'b1;
            end
            ST_SETTLE: if (tmr_zero) begin
                state_d = ST_TRIG;
                trig_d  = 1'b1;
            end
            ST_TRIG: begin
                state_d  = ST_WAIT;
                tmr_load = 1'b1;
                tmr_val  = TIMEOUT_LOAD;
            end
            ST_WAIT: if (us_done || tmr_zero) begin
                for (int i = 0; i < 3; i++) begin
                    if (idx_q == 2'(i)) begin
                        dist_d[i]  = us_done ? us_dist : DIST_W'(DIST_TIMEOUT);
                        flags_d[i] = flags_q[i] | ~us_done;
                    end
                end
                tmr_load = 1'b1;
                state_d  = (idx_q == 2'd2) ? ST_PARK : ST_SETTLE;
                pos_d    = (idx_q == 2'd2) ? POS_P1 : idx_q + 2'd1;
                idx_d    = (idx_q == 2'd2) ? idx_q : idx_q + 2'd1;
            end
            ST_PARK: if (tmr_zero) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            pos_q   <= POS_P1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            trig_q  <= 1'b0;
            flags_q <= 3'b000;
            dist_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            trig_q  <= trig_d;
            flags_q <= flags_d;
            dist_q  <= dist_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pos           = pos_q;
    assign us_trig       = trig_q;
    assign dist_p0       = dist_q[0];
    assign dist_p1       = dist_q[1];
    assign dist_p2       = dist_q[2];
    assign timeout_flags = flags_q;

endmodule

// File: tb/tb_servo_scan_ctrl.sv
// tb_servo_scan_ctrl: timeline-model bench for the servo scan sequencer
module tb_servo_scan_ctrl;

    localparam int S = 10;
    localparam int T = 20;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         us_done = 1'b0;
    logic [W-1:0] us_dist = '0;
    logic         busy, done, us_trig;
    logic [1:0]   pos;
    logic [W-1:0] dist_p0, dist_p1, dist_p2;
    logic [2:0]   timeout_flags;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_dist [3];
    logic [2:0]   m_flags;

    servo_scan_ctrl #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .DIST_W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .pos           (pos),
        .us_trig       (us_trig),
        .us_done       (us_done),
        .us_dist       (us_dist),
        .dist_p0       (dist_p0),
        .dist_p1       (dist_p1),
        .dist_p2       (dist_p2),
        .timeout_flags (timeout_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " pos"}, 32'(pos), 32'h1);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " done"}, 32'(done), 32'h0);
        chk({tag, " us_trig"}, 32'(us_trig), 32'h0);
        chk({tag, " dist_p0"}, 32'(dist_p0), 32'h0);
        chk({tag, " dist_p1"}, 32'(dist_p1), 32'h0);
        chk({tag, " dist_p2"}, 32'(dist_p2), 32'h0);
        chk({tag, " flags"}, 32'(timeout_flags), 32'h0);
    endtask

    // One scan. dN is the ranging latency after each trigger (beyond T means no answer in time).
    // Expected behaviour is a timeline: trigger S cycles after each position change, the
    // position moves on the cycle the result lands, done S cycles after the return to centre.
    task automatic run_scan(input int d0, input int d1, input int d2,
                            input logic [W-1:0] v0, input logic [W-1:0] v1, input logic [W-1:0] v2,
                            input bit inj, input bit abort, input string name);
        int           d [3];
        int           t [3];
        int           w [3];
        bit           to [3];
        logic [W-1:0] v [3];
        logic [W-1:0] nv [3];
        logic [W-1:0] old [3];
        logic [W-1:0] edist;
        logic [1:0]   ep;
        logic [2:0]   ef;
        int           dd, resp_at, ntrig;
        d = '{d0, d1, d2};
        v = '{v0, v1, v2};
        for (int i = 0; i < 3; i++) begin
            t[i]   = (i == 0) ? S : w[i-1] + S;
            to[i]  = d[i] > T;
            w[i]   = t[i] + (to[i] ? T + 1 : d[i] + 1);
            nv[i]  = to[i] ? 16'hFFFF : v[i];
            old[i] = m_dist[i];
        end
        dd      = w[2] + S;
        resp_at = -1;
        ntrig   = 0;
        @(posedge clk); #1;
        start   = 1'b1;
        us_done = inj;
        us_dist = 16'hBEEF;
        for (int c = 0; c <= dd + 1; c++) begin
            @(posedge clk); #1;
            start   = inj && (c == 3 || c == t[0] + 2);
            us_done = 1'b0;
            us_dist = W'($urandom);
            ep = (c < w[0]) ? 2'd0 : (c < w[1]) ? 2'd1 : (c < w[2]) ? 2'd2 : 2'd1;
            for (int i = 0; i < 3; i++) ef[i] = to[i] && c >= w[i];
            chk($sformatf("%s pos c=%0d", name, c), 32'(pos), 32'(ep));
            chk($sformatf("%s busy c=%0d", name, c), 32'(busy), 32'(c < dd));
            chk($sformatf("%s done c=%0d", name, c), 32'(done), 32'(c == dd));
            chk($sformatf("%s us_trig c=%0d", name, c), 32'(us_trig),
                32'(c == t[0] || c == t[1] || c == t[2]));
            edist = (c >= w[0]) ? nv[0] : old[0];
            chk($sformatf("%s dist_p0 c=%0d", name, c), 32'(dist_p0), 32'(edist));
            edist = (c >= w[1]) ? nv[1] : old[1];
            chk($sformatf("%s dist_p1 c=%0d", name, c), 32'(dist_p1), 32'(edist));
            edist = (c >= w[2]) ? nv[2] : old[2];
            chk($sformatf("%s dist_p2 c=%0d", name, c), 32'(dist_p2), 32'(edist));
            chk($sformatf("%s flags c=%0d", name, c), 32'(timeout_flags), 32'(ef));
            if (abort && c == t[2] + 2) begin
                rst_n = 1'b0;
                #1;
                check_reset_state({name, " async"});
                m_dist  = '{default: '0};
                m_flags = 3'b000;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (us_trig === 1'b1) begin
                resp_at = c + d[(ntrig < 3) ? ntrig : 2];
                ntrig++;
            end
            if (c == resp_at) begin
                us_done = 1'b1;
                us_dist = v[ntrig - 1];
            end else if (inj && c == 2) begin
                us_done = 1'b1;
                us_dist = 16'h1234;
            end
        end
        m_dist  = nv;
        m_flags = {to[2], to[1], to[0]};
    endtask

    initial begin
        m_dist  = '{default: '0};
        m_flags = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_state("reset released");
        run_scan(5, 5, 5, 16'd100, 16'd200, 16'd300, 1'b0, 1'b0, "nominal");
        chk("nominal dist_p0 final", 32'(dist_p0), 32'd100);
        chk("nominal dist_p1 final", 32'(dist_p1), 32'd200);
        chk("nominal dist_p2 final", 32'(dist_p2), 32'd300);
        run_scan(5, 99, 5, W'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b0, "timeout_p1");
        chk("timeout_p1 dist_p1 final", 32'(dist_p1), 32'hFFFF);
        chk("timeout_p1 flags final", 32'(timeout_flags), 32'b010);
        run_scan(T, T, T + 1, W'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b0, "collision");
        chk("collision flags final", 32'(timeout_flags), 32'b100);
        run_scan(int'($urandom_range(1, T)), int'($urandom_range(1, T)), int'($urandom_range(1, T)),
                 W'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b0, "ignored_inputs");
        run_scan(5, 5, 5, W'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b1, "abort_p2");
        run_scan(3, 7, 12, W'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b0, "after_abort");
        for (int k = 0; k < 4; k++) begin
            run_scan(int'($urandom_range(1, T + 3)), int'($urandom_range(1, T + 3)),
                     int'($urandom_range(1, T + 3)), W'($urandom), W'($urandom), W'($urandom),
                     1'(k & 1), 1'b0, $sformatf("random%0d", k));
            chk($sformatf("random%0d flags final", k), 32'(timeout_flags), 32'(m_flags));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
